// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package cpu_pkg;

  localparam int   WORD_AW = 30;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_D   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // One-hot request mask for an owner ID, bit 0 = fetch, bit 1 = data.
  function automatic logic [1:0] owner_mask(input logic own);
    return own ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM signals of the arbiter; slave = arbiter side, master = CPU/SRAM side.
interface mem_arbiter_if #(
  parameter int AW = 8
);
  import cpu_pkg::*;

  logic               if_req;
  logic [WORD_AW-1:0] if_addr;
  logic               if_ack;
  logic [31:0]        if_rdata;
  logic               d_req;
  logic               d_we;
  logic [WORD_AW-1:0] d_addr;
  logic [31:0]        d_wdata;
  logic               d_ack;
  logic [31:0]        d_rdata;
  logic               err;
  logic               busy;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, err, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, err, busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant logic: masked requests, then round-robin or fixed data priority.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic       prio_mode,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic r0;
  logic r1;

  always_comb begin
    r0  = req0 & ~mask[0];
    r1  = req1 & ~mask[1];
    gnt = {r1, r0};
    // On contention grant whoever was not served last, unless data always wins.
    if (r0 && r1) gnt = (prio_mode || last == OWN_IF) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between the fetch and load/store requesters via req/ack.
//   state  | meaning
//   IDLE   | no transaction, arbitrate pending requests
//   ACCESS | drive SRAM for owner (or flag out-of-range), one cycle
//   WAIT   | count RD_LAT cycles of SRAM read latency
//   RESP   | ack owner, arbitrate the other requester back-to-back
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW        = 8,
  parameter int RD_LAT    = 1,
  parameter int DATA_PRIO = 0
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t             state_q;
  state_t             state_d;
  logic               owner_q;
  logic               last_q;
  logic               err_q;
  logic [1:0]         wait_cnt;
  logic [31:0]        if_rdata_q;
  logic [31:0]        d_rdata_q;
  logic [1:0]         arb_mask;
  logic [1:0]         gnt;
  logic [WORD_AW-1:0] own_addr;
  logic               oor;
  logic               own_read;

  assign own_addr = (owner_q == OWN_D) ? bus.d_addr : bus.if_addr;
  assign oor      = |own_addr[WORD_AW-1:AW];
  assign own_read = !((owner_q == OWN_D) && bus.d_we);
  // In RESP the just-served requester may still hold req, so exclude it.
  assign arb_mask = (state_q == ST_RESP) ? owner_mask(owner_q) : 2'b00;

  rr_arb2 u_arb (
    .req0      (bus.if_req),
    .req1      (bus.d_req),
    .last      (last_q),
    .prio_mode (DATA_PRIO != 0),
    .mask      (arb_mask),
    .gnt       (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.if_ack    = 1'b0;
    bus.d_ack     = 1'b0;
    bus.err       = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!oor) begin
          bus.mem_en    = 1'b1;
          bus.mem_addr  = own_addr[AW-1:0];
          bus.mem_we    = !own_read;
          bus.mem_wdata = bus.d_wdata;
        end
        state_d = (oor || !own_read) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == 2'd0) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.if_ack = (owner_q == OWN_IF);
        bus.d_ack  = (owner_q == OWN_D);
        bus.err    = err_q;
        state_d    = (|gnt) ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_IF;
      last_q     <= OWN_D;
      err_q      <= 1'b0;
      wait_cnt   <= 2'd0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if ((state_q == ST_IDLE || state_q == ST_RESP) && (|gnt)) owner_q <= gnt[1];
      if (state_q == ST_RESP) last_q <= owner_q;
      if (state_q == ST_ACCESS) begin
        err_q    <= oor;
        wait_cnt <= WAIT_LOAD;
        // Out-of-range reads answer zero in the RESP cycle.
        if (oor && own_read) begin
          if (owner_q == OWN_D) d_rdata_q  <= '0;
          else                  if_rdata_q <= '0;
        end
      end
      if (state_q == ST_WAIT) begin
        if (wait_cnt == 2'd0) begin
          if (owner_q == OWN_D) d_rdata_q  <= bus.mem_rdata;
          else                  if_rdata_q <= bus.mem_rdata;
        end else begin
          wait_cnt <= wait_cnt - 2'd1;
        end
      end
    end
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: u0 (RD_LAT=1, round-robin) and u1 (RD_LAT=3, data priority) with SRAM models.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   n_chk = 0;
  int   n_err = 0;
  int   en_cnt0 = 0;
  int   we_cnt0 = 0;
  int   en_base;
  int   we_base;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(8)) b0 ();
  mem_arbiter_if #(.AW(8)) b1 ();

  mem_arbiter #(.AW(8), .RD_LAT(1), .DATA_PRIO(0)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  mem_arbiter #(.AW(8), .RD_LAT(3), .DATA_PRIO(1)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] rd0;
  logic [31:0] p1;
  logic [31:0] p2;
  logic [31:0] p3;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] <= 32'h0;
      mem1[i] <= 32'h0;
    end
    mem0[3]  <= 32'h24040006;
    mem0[7]  <= 32'h00000077;
    mem1[4]  <= 32'h00000044;
    mem1[9]  <= 32'h00000099;
    mem1[12] <= 32'h00001212;
    rd0 <= 32'h0;
    p1  <= 32'h0;
    p2  <= 32'h0;
    p3  <= 32'h0;
  end

  always @(posedge clk) begin
    if (b0.mem_en && b0.mem_we)  mem0[b0.mem_addr] <= b0.mem_wdata;
    if (b0.mem_en && !b0.mem_we) rd0 <= mem0[b0.mem_addr];
    if (b1.mem_en && b1.mem_we)  mem1[b1.mem_addr] <= b1.mem_wdata;
    if (b1.mem_en && !b1.mem_we) p1 <= mem1[b1.mem_addr];
    p2 <= p1;
    p3 <= p2;
    if (b0.mem_en) en_cnt0++;
    if (b0.mem_we) we_cnt0++;
  end

  assign b0.mem_rdata = rd0;
  assign b1.mem_rdata = p3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    repeat (2) step();
    check_eq("rst_busy",     b0.busy,     32'd0);
    check_eq("rst_mem_en",   b0.mem_en,   32'd0);
    check_eq("rst_mem_addr", 32'(b0.mem_addr), 32'd0);
    check_eq("rst_acks",     {b0.if_ack, b0.d_ack, b0.err}, 32'd0);
    check_eq("rst_if_rdata", b0.if_rdata, 32'd0);
    check_eq("rst_d_rdata",  b0.d_rdata,  32'd0);
    check_eq("rst_busy_u1",  b1.busy,     32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    step();

    // single fetch
    b0.if_addr = 30'd3; b0.if_req = 1'b1;
    step();
    check_eq("f_mem_en",   b0.mem_en, 32'd1);
    check_eq("f_mem_addr", 32'(b0.mem_addr), 32'd3);
    check_eq("f_mem_we",   b0.mem_we, 32'd0);
    step();
    check_eq("f_no_ack_c2", b0.if_ack, 32'd0);
    step();
    check_eq("f_if_ack",   b0.if_ack,   32'd1);
    check_eq("f_if_rdata", b0.if_rdata, 32'h24040006);
    check_eq("f_d_ack",    b0.d_ack,    32'd0);
    b0.if_req = 1'b0;
    step();
    check_eq("f_idle", b0.busy, 32'd0);

    // store then load
    we_base = we_cnt0;
    b0.d_we = 1'b1; b0.d_addr = 30'd5; b0.d_wdata = 32'hDEADBEEF; b0.d_req = 1'b1;
    step();
    check_eq("st_mem_we",    b0.mem_we, 32'd1);
    check_eq("st_mem_addr",  32'(b0.mem_addr), 32'd5);
    check_eq("st_mem_wdata", b0.mem_wdata, 32'hDEADBEEF);
    step();
    check_eq("st_d_ack",   b0.d_ack, 32'd1);
    check_eq("st_err",     b0.err, 32'd0);
    check_eq("st_d_rdata", b0.d_rdata, 32'd0);
    check_eq("st_we_once", 32'(we_cnt0 - we_base), 32'd1);
    b0.d_req = 1'b0; b0.d_we = 1'b0;
    step();
    b0.d_req = 1'b1;
    step();
    check_eq("ld_mem_en", b0.mem_en, 32'd1);
    check_eq("ld_mem_we", b0.mem_we, 32'd0);
    step(); step();
    check_eq("ld_d_ack",   b0.d_ack, 32'd1);
    check_eq("ld_d_rdata", b0.d_rdata, 32'hDEADBEEF);
    check_eq("ld_err",     b0.err, 32'd0);
    b0.d_req = 1'b0;
    step();

    // contention after reset: fetch first, data back-to-back
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    b0.if_addr = 30'd3; b0.if_req = 1'b1; b0.d_addr = 30'd5; b0.d_req = 1'b1;
    step();
    check_eq("c_first_if", 32'(b0.mem_addr), 32'd3);
    step(); step();
    check_eq("c_if_ack", {b0.if_ack, b0.d_ack}, 32'b10);
    b0.if_req = 1'b0;
    step();
    check_eq("c_d_access", {b0.mem_en, b0.busy}, 32'b11);
    check_eq("c_d_addr",   32'(b0.mem_addr), 32'd5);
    step(); step();
    check_eq("c_d_ack",    {b0.if_ack, b0.d_ack}, 32'b01);
    check_eq("c_d_rdata",  b0.d_rdata, 32'hDEADBEEF);
    b0.d_req = 1'b0;
    step();
    b0.if_addr = 30'd7; b0.if_req = 1'b1;
    repeat (3) step();
    check_eq("c_lone_if", b0.if_rdata, 32'h77);
    b0.if_req = 1'b0;
    step();
    b0.if_req = 1'b1; b0.d_req = 1'b1;
    step();
    check_eq("c2_d_wins", 32'(b0.mem_addr), 32'd5);
    step(); step();
    check_eq("c2_d_ack", {b0.if_ack, b0.d_ack}, 32'b01);
    b0.d_req = 1'b0;
    step();
    check_eq("c2_if_b2b", {b0.mem_en, 24'(0), b0.mem_addr}, {1'b1, 24'(0), 8'd7});
    step(); step();
    check_eq("c2_if_ack", {b0.if_ack, b0.d_ack}, 32'b10);
    b0.if_req = 1'b0;
    step();

    // out-of-range load
    en_base = en_cnt0;
    b0.d_addr = 30'h100; b0.d_we = 1'b0; b0.d_req = 1'b1;
    step();
    check_eq("oor_mem_en", b0.mem_en, 32'd0);
    check_eq("oor_busy",   b0.busy, 32'd1);
    step();
    check_eq("oor_ack_err", {b0.d_ack, b0.err}, 32'b11);
    check_eq("oor_rdata",   b0.d_rdata, 32'd0);
    check_eq("oor_no_en",   32'(en_cnt0 - en_base), 32'd0);
    b0.d_req = 1'b0;
    step();
    check_eq("oor_err_clr", {b0.err, b0.busy}, 32'd0);

    // data priority with RD_LAT=3
    b1.if_addr = 30'd9; b1.d_addr = 30'd4; b1.if_req = 1'b1; b1.d_req = 1'b1;
    step();
    check_eq("p_d_first", 32'(b1.mem_addr), 32'd4);
    repeat (4) step();
    check_eq("p_d_ack",   {b1.if_ack, b1.d_ack}, 32'b01);
    check_eq("p_d_rdata", b1.d_rdata, 32'h44);
    step();
    check_eq("p_if_b2b",  32'(b1.mem_addr), 32'd9);
    repeat (4) step();
    check_eq("p_if_ack",   {b1.if_ack, b1.d_ack}, 32'b10);
    check_eq("p_if_rdata", b1.if_rdata, 32'h99);
    step();
    check_eq("p_d_again", {b1.mem_en, 23'(0), b1.mem_addr}, {1'b1, 23'(0), 8'd4});
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    repeat (4) step();
    check_eq("p_drop_ack", {b1.if_ack, b1.d_ack}, 32'b01);
    step();
    check_eq("p_idle", b1.busy, 32'd0);

    // reset during WAIT aborts the read
    b1.if_addr = 30'd12; b1.if_req = 1'b1;
    step(); step();
    check_eq("r_in_wait", b1.busy, 32'd1);
    rst1 = 1'b1;
    step();
    check_eq("r_busy",   b1.busy, 32'd0);
    check_eq("r_outs",   {b1.if_ack, b1.d_ack, b1.err, b1.mem_en, b1.mem_we}, 32'd0);
    check_eq("r_rdata",  b1.if_rdata | b1.d_rdata, 32'd0);
    rst1 = 1'b0;
    step();
    check_eq("r_reissue", 32'(b1.mem_addr), 32'd12);
    repeat (3) step();
    check_eq("r_no_early", b1.if_ack, 32'd0);
    step();
    check_eq("r_if_ack",   b1.if_ack, 32'd1);
    check_eq("r_if_rdata", b1.if_rdata, 32'h1212);
    b1.if_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
